threshold_sequencer: RTL and testbench

THRESHOLD_SEQUENCER -- requirements
Module: threshold_sequencer

---
 rtl/threshold_sequencer.sv | 137 +++++++++++++
 tb/tb_threshold_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_sequencer.sv
// Frame sequencer for a dual-threshold pixel classifier: holds shadow/active
// thresholds, walks a frame of IMG_WIDTH x IMG_HEIGHT pixels and latches strong/weak totals.
module threshold_sequencer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int DEF_UPPER  = 220,
   parameter int DEF_LOWER  = 85
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_write,
   input  logic [7:0]  cfg_upper,
   input  logic [7:0]  cfg_lower,
   output logic        cfg_err,
   input  logic        start,
   input  logic        abort,
   input  logic        pix_valid,
   input  logic [7:0]  pix_in,
   output logic        thr_en,
   output logic [7:0]  thr_upper,
   output logic [7:0]  thr_lower,
   output logic        busy,
   output logic        frame_done,
   output logic [18:0] strong_cnt,
   output logic [18:0] weak_cnt
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [7:0]       shadowUpper_q, shadowLower_q;
   logic [7:0]       activeUpper_q, activeLower_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [18:0]      strongWork_q, weakWork_q;
   logic [18:0]      strongCnt_q, weakCnt_q;
   logic             thrEn_q, busy_q, frameDone_q, cfgErr_q;

   logic [18:0]      strongWork_d, weakWork_d;
   logic             lastPixel, cfgOk;

   // Working counts including the pixel currently presented, so the final
   // pixel can be folded straight into the latched totals.
   always_comb begin
      strongWork_d = strongWork_q + 19'(pix_in > activeUpper_q);
      weakWork_d   = weakWork_q   + 19'(pix_in < activeLower_q);
      lastPixel    = (col_q == COL_LAST) && (row_q == ROW_LAST);
      cfgOk        = cfg_lower < cfg_upper;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         shadowUpper_q <= 8'(DEF_UPPER);
         shadowLower_q <= 8'(DEF_LOWER);
         activeUpper_q <= 8'(DEF_UPPER);
         activeLower_q <= 8'(DEF_LOWER);
         col_q         <= '0;
         row_q         <= '0;
         strongWork_q  <= '0;
         weakWork_q    <= '0;
         strongCnt_q   <= '0;
         weakCnt_q     <= '0;
         thrEn_q       <= 1'b0;
         busy_q        <= 1'b0;
         frameDone_q   <= 1'b0;
         cfgErr_q      <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         cfgErr_q    <= 1'b0;
         if (cfg_write) begin
            if (cfgOk) begin
               shadowUpper_q <= cfg_upper;
               shadowLower_q <= cfg_lower;
            end else begin
               cfgErr_q <= 1'b1;
            end
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q       <= RUN;
                  activeUpper_q <= shadowUpper_q;
                  activeLower_q <= shadowLower_q;
                  col_q         <= '0;
                  row_q         <= '0;
                  strongWork_q  <= '0;
                  weakWork_q    <= '0;
                  thrEn_q       <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            RUN: begin
               // Abort takes precedence even over the final pixel of the frame.
               if (abort) begin
                  state_q <= IDLE;
                  thrEn_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (pix_valid) begin
                  strongWork_q <= strongWork_d;
                  weakWork_q   <= weakWork_d;
                  if (lastPixel) begin
                     state_q     <= DONE;
                     thrEn_q     <= 1'b0;
                     busy_q      <= 1'b0;
                     frameDone_q <= 1'b1;
                     strongCnt_q <= strongWork_d;
                     weakCnt_q   <= weakWork_d;
                  end else if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + ROW_W'(1);
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign thr_en     = thrEn_q;
   assign thr_upper  = activeUpper_q;
   assign thr_lower  = activeLower_q;
   assign busy       = busy_q;
   assign frame_done = frameDone_q;
   assign strong_cnt = strongCnt_q;
   assign weak_cnt   = weakCnt_q;
   assign cfg_err    = cfgErr_q;

endmodule

// File: tb/tb_threshold_sequencer.sv
// Directed-plus-random bench for threshold_sequencer on a 4x2 frame, checked
// against a frame-level model of thresholds and pixel classification.
module tb_threshold_sequencer;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int TOTAL = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_write;
   logic [7:0]  cfg_upper, cfg_lower;
   logic        cfg_err;
   logic        start, abort, pix_valid;
   logic [7:0]  pix_in;
   logic        thr_en;
   logic [7:0]  thr_upper, thr_lower;
   logic        busy, frame_done;
   logic [18:0] strong_cnt, weak_cnt;

   threshold_sequencer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .DEF_UPPER (220),
      .DEF_LOWER (85)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_write (cfg_write),
      .cfg_upper (cfg_upper),
      .cfg_lower (cfg_lower),
      .cfg_err   (cfg_err),
      .start     (start),
      .abort     (abort),
      .pix_valid (pix_valid),
      .pix_in    (pix_in),
      .thr_en    (thr_en),
      .thr_upper (thr_upper),
      .thr_lower (thr_lower),
      .busy      (busy),
      .frame_done(frame_done),
      .strong_cnt(strong_cnt),
      .weak_cnt  (weak_cnt)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Frame-level model: thresholds, last latched totals and the frame in flight.
   int shadowUp, shadowLo, activeUp, activeLo;
   int lastStrong, lastWeak, frameStrong, frameWeak, pixCount;
   int pixQ[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic cw, input logic [7:0] cu, input logic [7:0] cl,
                                input logic st, input logic ab, input logic pv,
                                input logic [7:0] pi);
      cfg_write = cw; cfg_upper = cu; cfg_lower = cl;
      start = st; abort = ab; pix_valid = pv; pix_in = pi;
      @(posedge clk);
      #1;
      cfg_write = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
   endtask

   task automatic modelReset();
      shadowUp = 220; shadowLo = 85; activeUp = 220; activeLo = 85;
      lastStrong = 0; lastWeak = 0; frameStrong = 0; frameWeak = 0; pixCount = 0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_upper"}, 32'(thr_upper), 220);
      checkOutput({tag, "_lower"}, 32'(thr_lower), 85);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_thren"}, 32'(thr_en), 0);
      checkOutput({tag, "_done"}, 32'(frame_done), 0);
      checkOutput({tag, "_err"}, 32'(cfg_err), 0);
      checkOutput({tag, "_strong"}, 32'(strong_cnt), 0);
      checkOutput({tag, "_weak"}, 32'(weak_cnt), 0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   task automatic cfgWrite(input int u, input int l);
      applyStimulus(1'b1, 8'(u), 8'(l), 1'b0, 1'b0, 1'b0, 8'd0);
      if (l < u) begin
         shadowUp = u; shadowLo = l;
      end
      checkOutput("cfg_err", 32'(cfg_err), (l < u) ? 0 : 1);
      checkOutput("cfg_active_upper", 32'(thr_upper), activeUp);
   endtask

   task automatic startFrame(input bit withCfg, input int u, input int l);
      applyStimulus(withCfg, 8'(u), 8'(l), 1'b1, 1'b0, 1'b0, 8'd0);
      activeUp = shadowUp; activeLo = shadowLo;
      if (withCfg && l < u) begin
         shadowUp = u; shadowLo = l;
      end
      frameStrong = 0; frameWeak = 0; pixCount = 0;
      checkOutput("start_busy", 32'(busy), 1);
      checkOutput("start_thren", 32'(thr_en), 1);
      checkOutput("start_upper", 32'(thr_upper), activeUp);
      checkOutput("start_lower", 32'(thr_lower), activeLo);
      checkOutput("start_err", 32'(cfg_err), (withCfg && !(l < u)) ? 1 : 0);
   endtask

   task automatic sendPixels(input int n, input bit abortLast);
      for (int i = 0; i < n; i++) begin
         int gap;
         int p;
         int sel;
         bit ab;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 8'd0, 8'd0, 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0,
                          8'($urandom_range(0, 255)));
            checkOutput("gap_busy", 32'(busy), 1);
            checkOutput("gap_done", 32'(frame_done), 0);
         end
         if (pixQ.size() > 0) begin
            p = pixQ.pop_front();
         end else begin
            sel = $urandom_range(0, 5);
            p = (sel == 0) ? activeUp : (sel == 1) ? activeLo : $urandom_range(0, 255);
         end
         ab = abortLast && (i == n - 1);
         applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, ab, 1'b1, 8'(p));
         if (ab) begin
            checkOutput("abort_busy", 32'(busy), 0);
            checkOutput("abort_thren", 32'(thr_en), 0);
            checkOutput("abort_done", 32'(frame_done), 0);
            checkOutput("abort_strong", 32'(strong_cnt), lastStrong);
            checkOutput("abort_weak", 32'(weak_cnt), lastWeak);
         end else begin
            pixCount++;
            if (p > activeUp) frameStrong++;
            if (p < activeLo) frameWeak++;
            if (pixCount == TOTAL) begin
               lastStrong = frameStrong; lastWeak = frameWeak;
               checkOutput("final_done", 32'(frame_done), 1);
               checkOutput("final_busy", 32'(busy), 0);
               checkOutput("final_strong", 32'(strong_cnt), lastStrong);
               checkOutput("final_weak", 32'(weak_cnt), lastWeak);
            end else begin
               checkOutput("pix_busy", 32'(busy), 1);
               checkOutput("pix_done", 32'(frame_done), 0);
            end
         end
      end
   endtask

   task automatic afterFrame(input bit startInDone);
      applyStimulus(1'b0, 8'd0, 8'd0, startInDone, 1'b0, 1'b1, 8'd255);
      checkOutput("post_done", 32'(frame_done), 0);
      checkOutput("post_busy", 32'(busy), 0);
      checkOutput("post_thren", 32'(thr_en), 0);
      checkOutput("post_strong", 32'(strong_cnt), lastStrong);
      checkOutput("post_weak", 32'(weak_cnt), lastWeak);
   endtask

   initial begin
      rst = 1'b1;
      cfg_write = 1'b0; cfg_upper = 8'd0; cfg_lower = 8'd0;
      start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      checkResetOutputs("reset");

      // Reference frame with known totals; start in the DONE cycle is ignored.
      pixQ = '{250, 10, 100, 220, 85, 221, 0, 84};
      startFrame(1'b0, 0, 0);
      sendPixels(8, 1'b0);
      checkOutput("ref_strong", 32'(strong_cnt), 2);
      checkOutput("ref_weak", 32'(weak_cnt), 3);
      afterFrame(1'b1);

      // Rejected configuration.
      cfgWrite(60, 60);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      checkOutput("err_clear", 32'(cfg_err), 0);
      checkOutput("err_upper", 32'(thr_upper), 220);
      checkOutput("err_lower", 32'(thr_lower), 85);

      // Config mid-frame only takes effect on the following start.
      startFrame(1'b0, 0, 0);
      sendPixels(3, 1'b0);
      cfgWrite(200, 50);
      checkOutput("run_cfg_busy", 32'(busy), 1);
      checkOutput("run_cfg_lower", 32'(thr_lower), 85);
      sendPixels(5, 1'b0);
      afterFrame(1'b0);

      // Abort after five pixels; idle pixels and idle abort are ignored.
      startFrame(1'b0, 0, 0);
      checkOutput("new_upper", 32'(thr_upper), 200);
      checkOutput("new_lower", 32'(thr_lower), 50);
      sendPixels(5, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      checkOutput("abort5_busy", 32'(busy), 0);
      checkOutput("abort5_done", 32'(frame_done), 0);
      checkOutput("abort5_strong", 32'(strong_cnt), lastStrong);
      checkOutput("abort5_weak", 32'(weak_cnt), lastWeak);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'(k == 1), 1'b1, 8'(k * 80));
         checkOutput("idle_done", 32'(frame_done), 0);
         checkOutput("idle_busy", 32'(busy), 0);
         checkOutput("idle_strong", 32'(strong_cnt), lastStrong);
      end
      startFrame(1'b0, 0, 0);
      sendPixels(8, 1'b0);
      afterFrame(1'b0);

      // Start coincident with cfg_write uses the old shadow; reset mid-frame.
      startFrame(1'b1, 150, 30);
      checkOutput("samecyc_upper", 32'(thr_upper), 200);
      sendPixels(3, 1'b0);
      doReset();
      checkResetOutputs("midreset");
      startFrame(1'b0, 0, 0);
      checkOutput("postrst_upper", 32'(thr_upper), 220);
      sendPixels(8, 1'b0);
      afterFrame(1'b0);

      // Abort coincident with the final pixel wins.
      startFrame(1'b0, 0, 0);
      sendPixels(7, 1'b0);
      sendPixels(1, 1'b1);
      afterFrame(1'b0);

      // Random configuration and frames.
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 1) == 1) begin
            cfgWrite($urandom_range(0, 255), $urandom_range(0, 255));
         end
         startFrame(1'($urandom_range(0, 3) == 0), $urandom_range(0, 255), $urandom_range(0, 255));
         sendPixels(8, 1'b0);
         afterFrame(1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
